// File: rtl/uart_pkg.sv
// Shared state encoding, frame constants and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a 1->0 edge detect
// on the synchronised copy. All flops reset to 1 so the idle line is not seen as a start.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_m;
  logic rx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

endmodule

// File: rtl/uart_rx_mid.sv
// UART receiver: start, 8 data bits LSB first, odd parity, one stop bit, sampled mid-bit.
// Define UART_RX_MAJORITY_EN to replace the single mid-bit sample by a 2-of-3 vote.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | half-bit wait, then confirm the start bit is still low
// DATA   | one sample per bit period into shift[idx], idx 0..7
// PARITY | one bit period, then capture the parity bit
// STOP   | one bit period, then capture the stop bit and schedule delivery
module uart_rx_mid #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic       donerx,
  output logic       par_err,
  output logic       frm_err
);

  import uart_pkg::*;

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  rx_state_t      state;
  rx_state_t      state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_nxt;
  logic           shift_en;
  logic           par_en;
  logic           stop_en;

  logic                 rx_s;
  logic                 fall;
  logic                 bit_smp;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 stop_bit;
  logic                 deliver;
  logic                 armed;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Starting one count lower pushes every decision to mid+1, where the vote is complete.
  localparam logic [CW-1:0] START_LOAD = '0;

  logic [1:0] rx_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  assign bit_smp = maj3(rx_hist[1], rx_hist[0], rx_s);
`else
  // The clock spent detecting the edge counts toward the half-bit wait.
  localparam logic [CW-1:0] START_LOAD = CW'(1);

  assign bit_smp = rx_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall && armed) begin
          state_nxt = START;
          cnt_nxt   = START_LOAD;
          idx_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = bit_smp ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          if (idx == IDX_LAST) begin
            state_nxt = PARITY;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          par_en    = 1'b1;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          stop_en   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift    <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      deliver  <= 1'b0;
      armed    <= 1'b1;
      rxdata   <= '0;
      donerx   <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      if (shift_en) begin
        shift[idx] <= bit_smp;
      end
      if (par_en) begin
        par_bit <= bit_smp;
      end
      if (stop_en) begin
        stop_bit <= bit_smp;
      end
      deliver <= stop_en;

      // A low stop bit (break) disarms edge detection until the line is seen high again.
      if (stop_en && (bit_smp != STOP_LVL)) begin
        armed <= 1'b0;
      end else if (rx_s) begin
        armed <= 1'b1;
      end

      donerx <= deliver;
      if (deliver) begin
        rxdata  <= shift;
        par_err <= (par_bit != ~^shift);
        frm_err <= (stop_bit != STOP_LVL);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mid.sv
// Directed plus randomized frames for uart_rx_mid, checked against a frame-level model.
module tb_uart_rx_mid;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 9600;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB + 2;
  localparam bit MAJ = 1'b1;
`else
  localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
  localparam bit MAJ = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rxdata;
  logic       donerx;
  logic       par_err;
  logic       frm_err;

  int     cyc   = 0;
  int     n_vec = 0;
  int     n_err = 0;
  int     t0;
  frame_t got_q[$];
  frame_t exp_q[$];
  int     stamp_q[$];

  uart_rx_mid #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rxdata  (rxdata),
    .donerx  (donerx),
    .par_err (par_err),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b1 && donerx === 1'b1) begin
      got_q.push_back({rxdata, par_err, frm_err});
      stamp_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What a correct receiver reports for a frame, given the line levels it sees at mid-bit.
  function automatic frame_t model(input logic [7:0] d, input logic p, input logic stop);
    frame_t f;
    f.d  = d;
    f.pe = (($countones({d, p}) % 2) == 0);
    f.fe = (stop == 1'b0);
    return f;
  endfunction

  // Drives one frame; gbit >= 0 inverts that data bit for one clock at its centre.
  // The line is left at the stop level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int gbit);
    logic [10:0] bits;
    logic [7:0]  seen;
    logic [7:0]  mask;
    bits = {stop, p, d, 1'b0};
    mask = 8'h01;
    seen = d;
    if (gbit >= 0 && !MAJ) seen = d ^ (mask << gbit);
    exp_q.push_back(model(seen, p, stop));
    for (int i = 0; i < 11; i++) begin
      if (gbit >= 0 && i == gbit + 1) begin
        rx = bits[i];
        tick(CPB / 2 - 1);
        rx = ~bits[i];
        tick(1);
        rx = bits[i];
        tick(CPB - CPB / 2);
      end else begin
        rx = bits[i];
        tick(CPB);
      end
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check({tag, "_data"}, got_q[i].d, exp_q[i].d);
        check({tag, "_par_err"}, got_q[i].pe, exp_q[i].pe);
        check({tag, "_frm_err"}, got_q[i].fe, exp_q[i].fe);
      end
    end
    got_q.delete();
    exp_q.delete();
    stamp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       stop;
    logic [7:0] d6;

    rst = 1'b0;
    rx  = 1'b1;
    tick(5);
    check("rst_donerx", donerx, 0);
    check("rst_rxdata", rxdata, 0);
    check("rst_par_err", par_err, 0);
    check("rst_frm_err", frm_err, 0);
    rst = 1'b1;
    tick(10);

    // 1: clean frame, latency measured from the rx fall
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    tick(CPB);
    check("t1_latency", (stamp_q.size() > 0) ? (stamp_q[0] - t0) : -1, LAT);
    check_frames("t1");

    // 2: wrong parity bit
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    tick(CPB);
    check_frames("t2");

    // 3: framing error followed by a held-low line
    send_frame(8'h81, 1'b1, 1'b0, -1);
    tick(3 * CPB);
    check_frames("t3_break");
    rx = 1'b1;
    tick(CPB);
    d = 8'($urandom_range(0, 255));
    send_frame(d, ~^d, 1'b1, -1);
    tick(CPB);
    check_frames("t3_after");

    // 4: short low pulse is rejected
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(2 * CPB);
    check("t4_glitch_count", got_q.size(), 0);
    send_frame(8'h5A, ~^8'h5A, 1'b1, -1);
    tick(CPB);
    check_frames("t4");

    // 5: back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    tick(CPB);
    check_frames("t5");

    // 6: reset in the middle of data bit 4
    d6 = 8'h96;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d6[i];
      tick(CPB);
    end
    rx = d6[4];
    tick(CPB / 2);
    rst = 1'b0;
    #1;
    check("t6_rst_donerx", donerx, 0);
    check("t6_rst_rxdata", rxdata, 0);
    check("t6_rst_par_err", par_err, 0);
    check("t6_rst_frm_err", frm_err, 0);
    rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2 * CPB);
    check("t6_abort_count", got_q.size(), 0);
    send_frame(d6, 1'b1, 1'b1, -1);
    tick(CPB);
    check_frames("t6");

    // 7: random bytes, parity and stop level, random idle gaps
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom_range(0, 255));
      p    = (~^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, p, stop, -1);
      if (!stop) begin
        rx = 1'b1;
        tick(CPB);
      end else begin
        tick($urandom_range(0, 40));
      end
    end
    tick(2 * CPB);
    check_frames("t7");

    // 8: one-clock glitch at the centre of a data bit
    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ~^d, 1'b1, $urandom_range(0, 7));
      tick($urandom_range(0, 20));
    end
    tick(2 * CPB);
    check_frames("t8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
